// File: rtl/serial_adder_if.sv
// Handshake and operand/result bundle for the bit-serial adder.
// The master drives start and the operands; the slave returns busy, done and the result.
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             c_out;

    modport master (
        output start, in1, in2,
        input  busy, done, sum, c_out
    );

    modport slave (
        input  start, in1, in2,
        output busy, done, sum, c_out
    );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder, LSB first: one full adder and a carry flop resolve one bit per clock.
// The result and carry-out stay registered until the next addition completes.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    serial_adder_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] ps_q, ps_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             c_q, c_d;
    logic             cout_q, cout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [1:0]       ha0_s;
    logic [1:0]       ha1_s;
    logic             s_s;
    logic             co_s;
    logic             last_bit_s;
    logic [WIDTH-1:0] ps_shift_s;

    // {carry, sum} of a single half-adder cell
    function automatic logic [1:0] half_add(input logic x, input logic y);
        return {x & y, x ^ y};
    endfunction

    // Full adder built from two half-adder cells; their carries never coincide, so OR merges them
    always_comb begin
        ha0_s      = half_add(a_q[0], b_q[0]);
        ha1_s      = half_add(ha0_s[0], c_q);
        s_s        = ha1_s[0];
        co_s       = ha0_s[1] | ha1_s[1];
        last_bit_s = (cnt_q == CW'(WIDTH - 1));
        ps_shift_s = ps_q >> 1;
        ps_shift_s[WIDTH-1] = s_s;
    end

    // State register plus registered status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: state_d = bus.start  ? ST_ADD  : ST_IDLE;
            ST_ADD:  state_d = last_bit_s ? ST_DONE : ST_ADD;
            ST_DONE: state_d = bus.start  ? ST_ADD  : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output logic: status flags follow the state being entered, so they register cleanly
    always_comb begin
        busy_d = 1'b0;
        done_d = 1'b0;
        case (state_d)
            ST_ADD:  busy_d = 1'b1;
            ST_DONE: done_d = 1'b1;
            default: busy_d = 1'b0;
        endcase
    end

    // Datapath next-state: operand load on accept, one bit per ADD edge, result copy on the last
    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        ps_d   = ps_q;
        sum_d  = sum_q;
        cnt_d  = cnt_q;
        c_d    = c_q;
        cout_d = cout_q;
        case (state_q)
            ST_ADD: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                ps_d  = ps_shift_s;
                c_d   = co_s;
                cnt_d = cnt_q + CW'(1);
                if (last_bit_s) begin
                    sum_d  = ps_shift_s;
                    cout_d = co_s;
                end else begin
                    sum_d  = sum_q;
                    cout_d = cout_q;
                end
            end
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    a_d   = bus.in1;
                    b_d   = bus.in2;
                    c_d   = 1'b0;
                    cnt_d = {CW{1'b0}};
                end else begin
                    cnt_d = cnt_q;
                end
            end
            default: cnt_d = cnt_q;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= {WIDTH{1'b0}};
            b_q    <= {WIDTH{1'b0}};
            ps_q   <= {WIDTH{1'b0}};
            sum_q  <= {WIDTH{1'b0}};
            cnt_q  <= {CW{1'b0}};
            c_q    <= 1'b0;
            cout_q <= 1'b0;
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            ps_q   <= ps_d;
            sum_q  <= sum_d;
            cnt_q  <= cnt_d;
            c_q    <= c_d;
            cout_q <= cout_d;
        end
    end

    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.sum   = sum_q;
    assign bus.c_out = cout_q;
endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8): an arithmetic reference model checked every
// cycle, plus directed operations with hand-computed results.
module tb_serial_adder;
    localparam int W = 8;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;
    int   done_cnt;
    bit   chk_en;

    serial_adder_if #(.WIDTH(W)) bus ();

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a result appears W edges after an accepted start
    int         m_rem;
    logic [8:0] m_pend;
    logic [7:0] m_sum;
    logic       m_cout;
    logic       m_done;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_rem  <= 0;
            m_pend <= 9'd0;
            m_sum  <= 8'd0;
            m_cout <= 1'b0;
            m_done <= 1'b0;
        end else begin
            m_done <= 1'b0;
            if (m_rem != 0) begin
                m_rem <= m_rem - 1;
                if (m_rem == 1) begin
                    m_sum  <= m_pend[7:0];
                    m_cout <= m_pend[8];
                    m_done <= 1'b1;
                end
            end else if (bus.start) begin
                m_pend <= {1'b0, bus.in1} + {1'b0, bus.in2};
                m_rem  <= W;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("model_busy",  {31'd0, bus.busy},  {31'd0, (m_rem != 0)});
                check("model_done",  {31'd0, bus.done},  {31'd0, m_done});
                check("model_sum",   {24'd0, bus.sum},   {24'd0, m_sum});
                check("model_c_out", {31'd0, bus.c_out}, {31'd0, m_cout});
            end
            if (bus.done) done_cnt++;
        end
    end

    // Single operation; counts busy cycles and checks the literal result
    task automatic run_op(input string name, input logic [7:0] a, input logic [7:0] b,
                          input bit scramble, input logic [7:0] exp_sum, input logic exp_c);
        int  bc;
        bit  found;
        bc = 0;
        found = 1'b0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.in1   = a;
        bus.in2   = b;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (scramble) begin
                bus.in1 = 8'h11;
                bus.in2 = 8'h11;
            end
            if (bus.busy) bc++;
            if (bus.done) begin
                found = 1'b1;
                break;
            end
        end
        check({name, "_done_seen"}, {31'd0, found}, 32'd1);
        check({name, "_busy_cycles"}, bc, 32'd8);
        check({name, "_sum"}, {24'd0, bus.sum}, {24'd0, exp_sum});
        check({name, "_c_out"}, {31'd0, bus.c_out}, {31'd0, exp_c});
        @(negedge clk);
        check({name, "_done_one_cycle"}, {31'd0, bus.done}, 32'd0);
    endtask

    initial begin
        int last_done;
        int d0;
        errors    = 0;
        checks    = 0;
        done_cnt  = 0;
        chk_en    = 1'b0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.in1   = 8'h00;
        bus.in2   = 8'h00;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        check("reset_busy",  {31'd0, bus.busy},  32'd0);
        check("reset_done",  {31'd0, bus.done},  32'd0);
        check("reset_sum",   {24'd0, bus.sum},   32'd0);
        check("reset_c_out", {31'd0, bus.c_out}, 32'd0);
        rst_n = 1'b1;

        run_op("zero", 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);

        run_op("ff_plus_1", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
        repeat (20) @(negedge clk);
        check("hold_sum",   {24'd0, bus.sum},   32'h00);
        check("hold_c_out", {31'd0, bus.c_out}, 32'd1);

        run_op("operand_change", 8'hA5, 8'h5A, 1'b1, 8'hFF, 1'b0);

        // Start pulses while busy must be ignored
        d0 = done_cnt;
        @(negedge clk);
        bus.start = 1'b1;
        bus.in1   = 8'h80;
        bus.in2   = 8'h80;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            bus.start = (i == 3 || i == 5);
        end
        check("busy_start_done_count", done_cnt - d0, 32'd1);
        check("busy_start_sum",   {24'd0, bus.sum},   32'h00);
        check("busy_start_c_out", {31'd0, bus.c_out}, 32'd1);

        // Start held high: back-to-back results every W+1 cycles
        d0 = done_cnt;
        last_done = -1;
        @(negedge clk);
        bus.start = 1'b1;
        bus.in1   = 8'h7F;
        bus.in2   = 8'h01;
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(negedge clk);
            if (bus.done) begin
                check("stream_sum",   {24'd0, bus.sum},   32'h80);
                check("stream_c_out", {31'd0, bus.c_out}, 32'd0);
                if (last_done >= 0) check("stream_period", cyc - last_done, 32'd9);
                last_done = cyc;
            end
        end
        check("stream_done_count", done_cnt - d0, 32'd3);
        bus.start = 1'b0;
        repeat (12) @(negedge clk);

        // Asynchronous reset in the middle of an addition
        bus.start = 1'b1;
        bus.in1   = 8'h33;
        bus.in2   = 8'h44;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        d0 = done_cnt;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_busy",  {31'd0, bus.busy},  32'd0);
        check("async_rst_done",  {31'd0, bus.done},  32'd0);
        check("async_rst_sum",   {24'd0, bus.sum},   32'd0);
        check("async_rst_c_out", {31'd0, bus.c_out}, 32'd0);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check("async_rst_no_done", done_cnt - d0, 32'd0);

        run_op("after_reset", 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
